// File: rtl/imu_spi_responder_pkg.sv
// Shared definitions for the IMU SPI responder: FSM states and frame constants.
package imu_spi_responder_pkg;

  localparam int BYTE_BITS    = 8;
  localparam int CMD_READ_BIT = 7;
  localparam int BIT_CNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } spi_state_e;

  function automatic logic [BYTE_BITS-1:0] shift_in(input logic [BYTE_BITS-2:0] cur,
                                                    input logic              bit_in);
    return {cur, bit_in};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an SPI pin plus an edge-detect flop giving 1-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      s3 <= RESET_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/imu_spi_responder.sv
// SPI mode-0 slave emulating the IMU register interface; all SPI pins are oversampled on clock.
// state | meaning
// IDLE  | ss high, miso held low
// CMD   | receiving command byte, shifting out status byte
// RD    | streaming reg[ptr] to miso, ptr advances per byte
// WR    | capturing bytes from mosi into reg[ptr], ptr advances per byte
module imu_spi_responder
  import imu_spi_responder_pkg::*;
#(
  parameter int                   ADDR_W      = 5,
  parameter logic [BYTE_BITS-1:0] STATUS_BYTE = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ss,
  input  logic                 sck,
  input  logic                 mosi,
  output logic                 miso,
  input  logic                 host_we,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [BYTE_BITS-1:0] host_wdata,
  output logic [BYTE_BITS-1:0] host_rdata,
  output logic                 wr_strobe,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [BYTE_BITS-1:0] wr_data,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic ss_level_unused, ss_rise, ss_fall;
  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset(reset), .din(ss),
    .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .clock(clock), .reset(reset), .din(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e state, state_nxt;

  logic [BYTE_BITS-1:0] mem [DEPTH];
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [BYTE_BITS-2:0] rx_shift, rx_nxt;
  logic [BYTE_BITS-1:0] tx_shift, tx_nxt;
  logic [ADDR_W-1:0]    ptr, ptr_nxt;
  logic                 got_byte, got_byte_nxt;
  logic                 mst_we;
  logic                 frame_done_nxt;

  logic [BYTE_BITS-1:0] rx_byte;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [ADDR_W-1:0]    ptr_inc;
  logic                 byte_end;

  assign rx_byte  = shift_in(rx_shift, mosi_s);
  assign cmd_addr = rx_byte[ADDR_W-1:0];
  assign ptr_inc  = ptr + 1'b1;
  assign byte_end = sck_rise && (bit_cnt == '1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    rx_nxt         = rx_shift;
    tx_nxt         = tx_shift;
    ptr_nxt        = ptr;
    got_byte_nxt   = got_byte;
    mst_we         = 1'b0;
    frame_done_nxt = 1'b0;

    if (state == IDLE) begin
      if (ss_fall) begin
        state_nxt    = CMD;
        tx_nxt       = STATUS_BYTE;
        bit_cnt_nxt  = '0;
        rx_nxt       = '0;
        got_byte_nxt = 1'b0;
      end
    end else if (ss_rise) begin
      state_nxt      = IDLE;
      tx_nxt         = '0;
      bit_cnt_nxt    = '0;
      rx_nxt         = '0;
      got_byte_nxt   = 1'b0;
      frame_done_nxt = got_byte;
    end else begin
      if (sck_rise) begin
        rx_nxt      = rx_byte[BYTE_BITS-2:0];
        bit_cnt_nxt = bit_cnt + 1'b1;
      end
      // The fall that follows a completed byte must not shift: tx was just reloaded.
      if (sck_fall && (bit_cnt != '0)) begin
        tx_nxt = tx_shift << 1;
      end
      if (byte_end) begin
        got_byte_nxt = 1'b1;
        case (state)
          CMD: begin
            ptr_nxt = cmd_addr;
            if (rx_byte[CMD_READ_BIT]) begin
              state_nxt = RD;
              tx_nxt    = mem[cmd_addr];
            end else begin
              state_nxt = WR;
              tx_nxt    = '0;
            end
          end
          RD: begin
            ptr_nxt = ptr_inc;
            tx_nxt  = mem[ptr_inc];
          end
          WR: begin
            mst_we  = 1'b1;
            ptr_nxt = ptr_inc;
            tx_nxt  = '0;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      ptr        <= '0;
      got_byte   <= 1'b0;
      frame_done <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      bit_cnt    <= bit_cnt_nxt;
      rx_shift   <= rx_nxt;
      tx_shift   <= tx_nxt;
      ptr        <= ptr_nxt;
      got_byte   <= got_byte_nxt;
      frame_done <= frame_done_nxt;
      wr_strobe  <= mst_we;
      if (mst_we) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
    end
  end

  // Single write port: the host side has priority over the master.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (host_we) begin
      mem[host_addr] <= host_wdata;
    end else if (mst_we) begin
      mem[ptr] <= rx_byte;
    end
  end

  assign host_rdata = mem[host_addr];
  assign miso       = tx_shift[BYTE_BITS-1];
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_imu_spi_responder.sv
// Bench for imu_spi_responder: directed and random SPI frames against a byte-array model.
module tb_imu_spi_responder;

  localparam int DEPTH = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ss = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic       host_we = 1'b0;
  logic [4:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       miso, wr_strobe, busy, frame_done;
  logic [7:0] host_rdata, wr_data;
  logic [4:0] wr_addr;

  always #10 clock = ~clock;

  imu_spi_responder #(.ADDR_W(5), .STATUS_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         fd_cnt  = 0;
  logic [4:0] wl_a[$];
  logic [7:0] wl_d[$];
  logic [7:0] ref_mem[DEPTH];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [4:0] coll_addr = '0;
  logic [7:0] coll_data = 8'h11;

  always @(negedge clock) begin
    if (frame_done) fd_cnt++;
    if (wr_strobe) begin
      wl_a.push_back(wr_addr);
      wl_d.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clock);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clock);
    host_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // One SPI bit takes 8 clocks: 4 low, 4 high. Starts and ends on a negedge with sck low.
  task automatic xfer_bits(input logic [7:0] b, input int nbits, input bit collide,
                           output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (4) @(negedge clock);
      r   = {r[6:0], miso};
      sck = 1'b1;
      if (collide && i == 7) begin
        // Host write lands on the same clock edge as the master's byte commit.
        repeat (2) @(negedge clock);
        host_we = 1'b1; host_addr = coll_addr; host_wdata = coll_data;
        @(negedge clock);
        host_we = 1'b0;
        @(negedge clock);
      end else begin
        repeat (4) @(negedge clock);
      end
      sck = 1'b0;
    end
  endtask

  task automatic do_frame(input int abort_bits, input int collide_idx);
    logic [7:0] exp_rx[$];
    logic [4:0] exp_a[$];
    logic [7:0] exp_d[$];
    logic [4:0] base, addr;
    logic [7:0] r;
    bit         rd;
    int         fd0;
    base = txq[0][4:0];
    rd   = txq[0][7];
    exp_rx.push_back(8'hA5);
    for (int k = 1; k < txq.size(); k++) begin
      addr = base + 5'(k - 1);
      if (rd) exp_rx.push_back(ref_mem[addr]);
      else begin
        exp_rx.push_back(8'h00);
        exp_a.push_back(addr);
        exp_d.push_back(txq[k]);
        if (k == collide_idx) coll_addr = addr;
      end
    end
    wl_a.delete(); wl_d.delete(); rxq.delete();
    fd0 = fd_cnt;
    @(negedge clock);
    ss = 1'b0;
    repeat (4) @(negedge clock);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int k = 0; k < txq.size(); k++) begin
      xfer_bits(txq[k], 8, (k == collide_idx), r);
      rxq.push_back(r);
    end
    if (abort_bits > 0) xfer_bits(8'($urandom), abort_bits, 1'b0, r);
    repeat (4) @(negedge clock);
    ss = 1'b1;
    repeat (4) @(negedge clock);
    check("busy_after_ss_rise", 32'(busy), 32'd0);
    check("miso_idle", 32'(miso), 32'd0);
    repeat (4) @(negedge clock);
    for (int k = 0; k < exp_rx.size(); k++)
      check($sformatf("rx_byte%0d", k), 32'(rxq[k]), 32'(exp_rx[k]));
    check("frame_done_count", 32'(fd_cnt - fd0), 32'd1);
    check("wr_strobe_count", 32'(wl_a.size()), 32'(exp_a.size()));
    for (int k = 0; k < exp_a.size() && k < wl_a.size(); k++) begin
      check($sformatf("wr_addr%0d", k), 32'(wl_a[k]), 32'(exp_a[k]));
      check($sformatf("wr_data%0d", k), 32'(wl_d[k]), 32'(exp_d[k]));
    end
    for (int k = 0; k < exp_a.size(); k++)
      ref_mem[exp_a[k]] = (k + 1 == collide_idx) ? coll_data : exp_d[k];
  endtask

  task automatic check_rdata(input logic [4:0] a, input logic [7:0] exp, input string tag);
    @(negedge clock);
    host_addr = a;
    #1;
    check(tag, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (10) @(negedge clock);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      host_addr = 5'(i);
      #1;
      check($sformatf("reset_rdata%0d", i), 32'(host_rdata), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Burst read of the preloaded block.
    for (int i = 0; i < 18; i++) host_write(5'(i), 8'(8'h10 + i));
    txq = {8'h80};
    for (int i = 0; i < 18; i++) txq.push_back(8'($urandom));
    do_frame(0, -1);
    check("burst_last_byte", 32'(rxq[18]), 32'h21);

    // Read wrapping from the top address.
    host_write(5'd31, 8'hEE);
    txq = {8'h9F, 8'h00, 8'h00};
    do_frame(0, -1);
    check("wrap_rx1", 32'(rxq[1]), 32'hEE);
    check("wrap_rx2", 32'(rxq[2]), 32'h10);

    // Master write.
    txq = {8'h04, 8'h5A, 8'hC3};
    do_frame(0, -1);
    check_rdata(5'd4, 8'h5A, "mwrite_rdata4");
    check_rdata(5'd5, 8'hC3, "mwrite_rdata5");

    // Abort after 3 bits of the first data byte, then a clean read.
    txq = {8'h80};
    do_frame(3, -1);
    txq = {8'h80, 8'h00, 8'h00};
    do_frame(0, -1);

    // Host and master write the same byte in the same cycle.
    coll_data = 8'h11;
    txq = {8'h06, 8'h22};
    do_frame(0, 1);
    check_rdata(5'd6, 8'h11, "collision_rdata6");

    // Random frames mixed with host writes.
    for (int it = 0; it < 25; it++) begin
      int nd, ab, ci;
      repeat ($urandom_range(0, 3)) host_write(5'($urandom), 8'($urandom));
      nd = $urandom_range(1, 6);
      txq = {8'($urandom)};
      for (int k = 0; k < nd; k++) txq.push_back(8'($urandom));
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      ci = (!txq[0][7] && $urandom_range(0, 3) == 0) ? $urandom_range(1, nd) : -1;
      coll_data = 8'($urandom);
      do_frame(ab, ci);
    end

    for (int i = 0; i < DEPTH; i++)
      check_rdata(5'(i), ref_mem[i], $sformatf("final_rdata%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
